// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes and FSM states.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's memory port and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_unit.sv
// Byte-lane steering: store byte enables and lane-shifted write data, load
// extraction with sign/zero extension, and size/alignment fault detection.
module mem_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  byteOff,
  input  logic [31:0] wdata,
  input  logic [31:0] rawWord,
  output logic [3:0]  byteEn,
  output logic [31:0] wdataLane,
  output logic [31:0] rdataExt,
  output logic        fault
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  assign byteVal   = rawWord[{byteOff, 3'b000} +: 8];
  assign halfVal   = rawWord[{byteOff[1], 4'b0000} +: 16];
  assign wdataLane = wdata << {byteOff, 3'b000};

  // Decode the size code into lane enables, extended load data and fault.
  always_comb begin
    byteEn   = 4'b0000;
    rdataExt = 32'd0;
    fault    = 1'b0;
    case (size)
      SZ_B: begin
        byteEn   = 4'b0001 << byteOff;
        rdataExt = {{24{byteVal[7]}}, byteVal};
      end
      SZ_BU: begin
        byteEn   = 4'b0001 << byteOff;
        rdataExt = {24'd0, byteVal};
      end
      SZ_H: begin
        byteEn   = byteOff[1] ? 4'b1100 : 4'b0011;
        rdataExt = {{16{halfVal[15]}}, halfVal};
        fault    = byteOff[0];
      end
      SZ_HU: begin
        byteEn   = byteOff[1] ? 4'b1100 : 4'b0011;
        rdataExt = {16'd0, halfVal};
        fault    = byteOff[0];
      end
      SZ_W: begin
        byteEn   = 4'b1111;
        rdataExt = rawWord;
        fault    = (byteOff != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding load/store, response
// LATENCY edges after accept, byte-lane stores and extended loads.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);

  dmem_state_t state;
  logic [3:0]  cnt;

  logic        latWe;
  logic [2:0]  latSize;
  logic [31:0] latAddr;
  logic [31:0] latWdata;

  logic        reqReady;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;

  logic        curWe;
  logic [2:0]  curSize;
  logic [31:0] curAddr;
  logic [31:0] curWdata;
  logic        goResp;

  logic [3:0]  laneBe;
  logic [31:0] laneWdata;
  logic [31:0] laneRdata;
  logic        laneFault;
  logic        reqFault;

  logic [31:0]       mem [(1 << ADDR_W)];
  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       rawWord;

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;

  // With LATENCY=1 the array is accessed on the accept edge itself, before the
  // latch holds the request, so the live bus is used while still in IDLE.
  always_comb begin
    curWe    = latWe;
    curSize  = latSize;
    curAddr  = latAddr;
    curWdata = latWdata;
    if (state == IDLE) begin
      curWe    = bus.req_we;
      curSize  = bus.req_size;
      curAddr  = bus.req_addr;
      curWdata = bus.req_wdata;
    end
  end

  // Flag the edge that enters RESP; the array access happens on that edge.
  always_comb begin
    goResp = 1'b0;
    if (state == IDLE && bus.req_valid && LATENCY == 1) goResp = 1'b1;
    if (state == WAIT && cnt == 4'd1)                   goResp = 1'b1;
  end

  assign wordIdx  = curAddr[ADDR_W+1:2];
  assign rawWord  = mem[wordIdx];
  assign reqFault = laneFault | ((curAddr >> (ADDR_W + 2)) != 32'd0);

  mem_lane_unit u_lane (
    .size      (curSize),
    .byteOff   (curAddr[1:0]),
    .wdata     (curWdata),
    .rawWord   (rawWord),
    .byteEn    (laneBe),
    .wdataLane (laneWdata),
    .rdataExt  (laneRdata),
    .fault     (laneFault)
  );

  // Request FSM, latency counter, request latch and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respRdata <= 32'd0;
      respErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            latWe    <= bus.req_we;
            latSize  <= bus.req_size;
            latAddr  <= bus.req_addr;
            latWdata <= bus.req_wdata;
            cnt      <= 4'(LATENCY - 1);
            reqReady <= 1'b0;
            state    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          reqReady  <= 1'b1;
          respValid <= 1'b0;
          respRdata <= 32'd0;
          respErr   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (goResp) begin
        respValid <= 1'b1;
        respErr   <= reqFault;
        respRdata <= (reqFault || curWe) ? 32'd0 : laneRdata;
      end
    end
  end

  // Lane-masked store on the RESP-entry edge; reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (goResp && !reset && curWe && !reqFault) begin
      for (int i = 0; i < 4; i++) begin
        if (laneBe[i]) mem[wordIdx][8*i +: 8] <= laneWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 1, 2 and 3.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int D1 = 0;
  localparam int D2 = 1;
  localparam int D3 = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqWe;
  logic [2:0]  reqSize;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [2:0]  vld;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();
  dmem_responder_if bus3 ();

  assign bus1.req_valid = vld[D1];
  assign bus2.req_valid = vld[D2];
  assign bus3.req_valid = vld[D3];
  assign bus1.req_we = reqWe;     assign bus2.req_we = reqWe;     assign bus3.req_we = reqWe;
  assign bus1.req_size = reqSize; assign bus2.req_size = reqSize; assign bus3.req_size = reqSize;
  assign bus1.req_addr = reqAddr; assign bus2.req_addr = reqAddr; assign bus3.req_addr = reqAddr;
  assign bus1.req_wdata = reqWdata; assign bus2.req_wdata = reqWdata; assign bus3.req_wdata = reqWdata;

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dmem_responder #(.ADDR_W(18), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  wire [2:0] rdyV  = {bus3.req_ready,  bus2.req_ready,  bus1.req_ready};
  wire [2:0] respV = {bus3.resp_valid, bus2.resp_valid, bus1.resp_valid};
  wire [2:0] errV  = {bus3.resp_err,   bus2.resp_err,   bus1.resp_err};
  logic [31:0] rdV [3];
  assign rdV[0] = bus1.resp_rdata;
  assign rdV[1] = bus2.resp_rdata;
  assign rdV[2] = bus3.resp_rdata;

  // One transaction: present at a negedge, drop valid and scramble the request
  // fields after the accept edge, wait (bounded) for resp_valid, end in IDLE.
  task automatic xfer(input int s, input logic we, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    reqWe = we; reqSize = sz; reqAddr = a; reqWdata = wd; vld[s] = 1'b1;
    @(negedge clk);
    vld[s] = 1'b0;
    reqWe = ~we; reqSize = 3'b111; reqAddr = 32'hFFFF_FFFC; reqWdata = ~wd;
    lat = 1;
    while (!respV[s] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!respV[s]) lat = -1;
    rd = rdV[s];
    er = errV[s];
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (rdyV !== 3'b111) begin bad++; $display("FAIL reset_ready: got %b want 111", rdyV); end
    total++; if (respV !== 3'b000) begin bad++; $display("FAIL reset_valid: got %b want 000", respV); end
    total++; if (errV !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", errV); end
    total++; if (rdV[D2] !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdV[D2]); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    total++; if (rdyV[D2] !== 1'b1) begin bad++; $display("FAIL sw_ready: got %b want 1", rdyV[D2]); end
    xfer(D2, 1'b1, SZ_W, 32'h100, 32'hDEADBEEF, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL sw_err: got %b want 0", er); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL sw_rdata: got %h want 0", rd); end
    xfer(D2, 1'b0, SZ_W, 32'h100, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_100: got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_100_err: got %b want 0", er); end
  endtask

  task automatic test_sub_word_loads();
    logic [31:0] rd; logic er; int lat;
    xfer(D2, 1'b1, SZ_W, 32'h200, 32'h80FF7F01, rd, er, lat);
    xfer(D2, 1'b0, SZ_B, 32'h203, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_203: got %h want ffffff80", rd); end
    xfer(D2, 1'b0, SZ_BU, 32'h203, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_203: got %h want 00000080", rd); end
    xfer(D2, 1'b0, SZ_H, 32'h202, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFF80FF) begin bad++; $display("FAIL lh_202: got %h want ffff80ff", rd); end
    xfer(D2, 1'b0, SZ_HU, 32'h200, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00007F01) begin bad++; $display("FAIL lhu_200: got %h want 00007f01", rd); end
    xfer(D2, 1'b0, SZ_B, 32'h201, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0000007F) begin bad++; $display("FAIL lb_201: got %h want 0000007f", rd); end
  endtask

  task automatic test_lane_store();
    logic [31:0] rd; logic er; int lat;
    xfer(D2, 1'b1, SZ_W, 32'h200, 32'h11223344, rd, er, lat);
    xfer(D2, 1'b1, SZ_B, 32'h201, 32'h123456AB, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL sb_201_err: got %b want 0", er); end
    xfer(D2, 1'b0, SZ_W, 32'h200, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h1122AB44) begin bad++; $display("FAIL sb_lane: got %h want 1122ab44", rd); end
    xfer(D2, 1'b1, SZ_H, 32'h202, 32'h9876BEEF, rd, er, lat);
    xfer(D2, 1'b0, SZ_W, 32'h200, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hBEEFAB44) begin bad++; $display("FAIL sh_lane: got %h want beefab44", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er; int lat;
    xfer(D2, 1'b0, SZ_W, 32'h102, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL lw_mis_err: got %b want 1", er); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL lw_mis_rdata: got %h want 0", rd); end
    xfer(D2, 1'b0, 3'b011, 32'h100, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL size011_err: got %b want 1", er); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL size011_rdata: got %h want 0", rd); end
    xfer(D2, 1'b0, SZ_HU, 32'h101, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL lhu_mis_err: got %b want 1", er); end
    xfer(D2, 1'b1, SZ_W, 32'h104, 32'hCAFEF00D, rd, er, lat);
    xfer(D2, 1'b1, SZ_H, 32'h105, 32'h00005555, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL sh_mis_err: got %b want 1", er); end
    xfer(D2, 1'b1, SZ_W, 32'h0100_0104, 32'h77777777, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL high_addr_err: got %b want 1", er); end
    xfer(D2, 1'b0, SZ_W, 32'h104, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL fault_nowrite: got %h want cafef00d", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL fault_nowrite_err: got %b want 0", er); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] rdyPat, vldPat;
    logic [31:0] rd; logic er; int lat;
    reqWe = 1'b1; reqSize = SZ_W; reqAddr = 32'h40; reqWdata = 32'h5A5A5A5A;
    vld[D3] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      rdyPat[n] = rdyV[D3];
      vldPat[n] = respV[D3];
      @(negedge clk);
    end
    vld[D3] = 1'b0;
    total++; if (rdyPat !== 12'h111) begin bad++; $display("FAIL b2b_ready: got %b want %b", rdyPat, 12'h111); end
    total++; if (vldPat !== 12'h888) begin bad++; $display("FAIL b2b_resp: got %b want %b", vldPat, 12'h888); end
    xfer(D3, 1'b0, SZ_W, 32'h40, 32'h0, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL lat3: got %0d want 3", lat); end
    total++; if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL b2b_data: got %h want 5a5a5a5a", rd); end
  endtask

  task automatic test_latency1();
    logic [31:0] rd; logic er; int lat;
    xfer(D1, 1'b1, SZ_B, 32'h10, 32'hFFFFFF77, rd, er, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL lat1_store: got %0d want 1", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL lat1_store_err: got %b want 0", er); end
    xfer(D1, 1'b0, SZ_BU, 32'h10, 32'h0, rd, er, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL lat1_load: got %0d want 1", lat); end
    total++; if (rd !== 32'h00000077) begin bad++; $display("FAIL lat1_lbu: got %h want 00000077", rd); end
    total++; if (rdyV[D1] !== 1'b1) begin bad++; $display("FAIL lat1_ready: got %b want 1", rdyV[D1]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    int seen;
    logic rdyAll;
    xfer(D3, 1'b1, SZ_W, 32'h300, 32'hAAAA5555, rd, er, lat);
    // Reset one cycle into WAIT at LATENCY=3.
    reqWe = 1'b1; reqSize = SZ_W; reqAddr = 32'h300; reqWdata = 32'h12345678; vld[D3] = 1'b1;
    @(negedge clk);
    vld[D3] = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0; rdyAll = 1'b1;
    repeat (6) begin
      if (respV[D3]) seen++;
      rdyAll &= rdyV[D3];
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_wait_resp: got %0d pulses want 0", seen); end
    total++; if (rdyAll !== 1'b1) begin bad++; $display("FAIL rst_wait_ready: got %b want 1", rdyAll); end
    xfer(D3, 1'b0, SZ_W, 32'h300, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hAAAA5555) begin bad++; $display("FAIL rst_wait_nowrite: got %h want aaaa5555", rd); end
    // Reset on the edge that would enter RESP at LATENCY=2.
    reqWe = 1'b1; reqSize = SZ_W; reqAddr = 32'h100; reqWdata = 32'h0BADF00D; vld[D2] = 1'b1;
    @(negedge clk);
    vld[D2] = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      if (respV[D2]) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_resp_edge: got %0d pulses want 0", seen); end
    xfer(D2, 1'b0, SZ_W, 32'h100, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_resp_nowrite: got %h want deadbeef", rd); end
  endtask

  // Main sequence.
  initial begin
    reset = 1'b1; vld = 3'b000;
    reqWe = 1'b0; reqSize = 3'b000; reqAddr = 32'd0; reqWdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_word();
    test_sub_word_loads();
    test_lane_store();
    test_faults();
    test_back_to_back();
    test_latency1();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core. It accepts one load or store request at a time over a valid/ready handshake and returns the response after a fixed, parameterised latency. Stores are byte-lane masked and loads are sign- or zero-extended, both driven by funct3-encoded size codes. It sits on the far side of the core's memory port and stands in for the zero-latency data memory when testing stall handling in the pipeline.

## Interface
- `ADDR_W`, default 18: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `LATENCY`, default 2: cycles from the accept edge to `resp_valid`; legal range is 1..15.
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  a request is present on the request signals.
- `req_ready`  out  1  the responder can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  3  funct3 size code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the value is LSB-aligned and is shifted to its byte lane internally.
- `resp_valid`  out  1  one-cycle pulse that marks the response.
- `resp_rdata`  out  32  extended load data; 0 for stores and for errors.
- `resp_err`  out  1  the request faulted; qualified by `resp_valid`.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_size`, `req_addr` and `req_wdata`, and load the counter with LATENCY-1.
  - Go to RESP if LATENCY=1, otherwise go to WAIT.
- **WAIT:**
  - `req_ready`=0.
  - Decrement the counter each cycle.
  - When the counter is 1, go to RESP.
- **RESP:**
  - `resp_valid`=1 for exactly one cycle, then return to IDLE.
  - There is no back-pressure: the initiator must take the response.
- **Fault checks:** evaluated on the latched request. The request faults if any of these holds:
  - `req_size` is 011, 110 or 111;
  - a halfword access has `addr[0]`=1;
  - a word access has `addr[1:0]`≠0;
  - `addr[31:ADDR_W+2]`≠0.
  - A faulting request returns `resp_err`=1 and `resp_rdata`=0, and it never writes the array.
- **Array access:** happens on the edge that enters RESP.
  - A store writes only its enabled lanes:
    - byte: one lane, selected by `addr[1:0]`;
    - half: lanes {1:0} or {3:2}, selected by `addr[1]`;
    - word: all four lanes.
  - A load registers the selected lanes, then sign-extends them (LB/LH) or zero-extends them (LBU/LHU). LW passes the word through.
- **Reset:**
  - Values: state=IDLE, counter=0, `req_ready`=1 from the first cycle after reset, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - Reset during WAIT drops the request and no write occurs.
  - Reset on the same edge that would enter RESP has priority, so no write occurs there either.
  - Array contents are not cleared by reset.

## Timing
- **Request accept:** the accept edge is the edge on which `req_valid`=1 and `req_ready`=1.
- **Response:** `resp_valid` is high in the cycle that begins LATENCY edges after the accept edge.
- **Back-to-back throughput:** one request per LATENCY+1 cycles.
  - `req_ready` is 0 from the accept edge through the RESP cycle.
  - `req_ready` returns to 1 in the cycle after `resp_valid`.
- **Signal sampling:** request signals are sampled only on the accept edge; changing them later has no effect.
- **Output validity:** `resp_rdata` and `resp_err` are registered. They are valid only while `resp_valid`=1 and are driven to 0 otherwise.
- **Read-after-write:** a load issued after a store's response returns the stored data; only one request is ever outstanding.

## Structure
- **`dmem_pkg`:** holds
  - the size localparams (SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101);
  - the state enum `dmem_state_t` {IDLE, WAIT, RESP}.
- **Sub-module `mem_lane_unit`:** purely combinational. It maps (size, `addr[1:0]`, wdata) to a byte-enable mask and shifted write data. It also maps (size, `addr[1:0]`, raw word) to extended load data and to the misalignment/illegal-size fault.
- **Top level:** holds the FSM, the latency counter, the request latch and the array.

## Test plan
- **Word store, then load (LATENCY=2):**
  - SW 0xDEADBEEF at addr 0x100: accepted while `req_ready`=1; `resp_valid` 2 cycles later with `resp_err`=0 and rdata=0.
  - LW at 0x100 returns 0xDEADBEEF.
- **Byte and half loads:** with 0x80FF7F01 stored at 0x200:
  - LB at 0x203 → 0xFFFFFF80;
  - LBU at 0x203 → 0x00000080;
  - LH at 0x202 → 0xFFFF80FF;
  - LHU at 0x200 → 0x00007F01.
- **Byte-lane store:** SB 0xAB at 0x201 over 0x11223344 at 0x200, then LW 0x200 → 0x1122AB44.
- **Faults:**
  - LW at 0x102 → `resp_err`=1, rdata=0;
  - `req_size`=3'b011 → `resp_err`=1;
  - SH at 0x101 → `resp_err`=1, and a later LW shows the word unchanged.
- **Handshake timing:**
  - With `req_valid` held high continuously at LATENCY=3, accepts occur every 4 cycles.
  - `req_ready` is 0 during WAIT and RESP.
  - With LATENCY=1, `resp_valid` appears the cycle after accept.
- **Reset mid-operation:**
  - Accept SW 0x12345678 at 0x300, then assert `reset` the next cycle (LATENCY=3).
  - Required response: no `resp_valid`, and `req_ready`=1 once reset is released.
  - A following LW at 0x300 returns the prior contents.
